fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction fetch stage of the 16-bit pipeline. Owns the program counter and drives the address into the combinational instruction memory.
- Captures the returned word into the IF/ID buffer.
- Applies hazard stalls, branch redirects and flushes, and stops fetching when it fetches a HALT word (16'h0000).
- Sits between the hazard/branch logic in later stages and the instruction memory / IF/ID boundary.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch (16-bit instructions).
- HALT_WORD, 16'h0000, instruction encoding treated as HALT.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  hold the PC and the IF/ID buffer this cycle (load-use or structural hazard).
- branch_taken  input  1  redirect from a later stage; the wrong-path IF/ID content must be flushed.
- branch_target  input  16  redirect address; bit 0 is ignored (forced 0).
- instr_in  input  16  instruction word from instruction memory for the current pc_out (same cycle, combinational).
- pc_out  output  16  registered PC, addresses instruction memory.
- ifid_instr  output  16  IF/ID buffered instruction.
- ifid_pc  output  16  address of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction (0 = bubble).
- halted  output  1  fetch has stopped on HALT_WORD.
- fetch_count  output  16  number of valid instructions delivered into IF/ID; saturates at 16'hFFFF.

Behaviour:
- There is one clock. Reset is synchronous and active-high.
- Reset values (all outputs):
  - pc_out=RESET_PC, ifid_instr=16'h0000, ifid_pc=16'h0000.
  - ifid_valid=0, halted=0, fetch_count=0.
  - state=RUN.
- Asserting reset mid-operation aborts everything at the next edge, including a pending redirect or the HALT state.
- States:
  - RUN: fetching.
  - HALT: the PC is frozen after HALT_WORD has been captured.
- Per-edge priority is rst > branch_taken > stall > state action.
- branch_taken (either state):
  - pc_out<=branch_target&16'hFFFE.
  - ifid_valid<=0 and ifid_instr<=16'h0000 (flush).
  - ifid_pc<=0, halted<=0, state<=RUN.
  - branch_taken overrides a simultaneous stall.
  - A HALT fetched on the wrong path is cancelled this way.
- stall (no branch): pc_out, the IF/ID registers, fetch_count and state all hold. An IF/ID bubble stays a bubble.
- RUN, no stall/branch, instr_in!=HALT_WORD:
  - ifid_instr<=instr_in, ifid_pc<=pc_out, ifid_valid<=1.
  - pc_out<=pc_out+PC_STEP, computed mod 2^16, so 16'hFFFE wraps to 16'h0000.
  - fetch_count increments.
- RUN, no stall/branch, instr_in==HALT_WORD:
  - The HALT is captured like any other instruction (valid=1, fetch_count increments) so that it retires.
  - pc_out holds at the HALT address.
  - halted<=1, state<=HALT.
- HALT, no stall/branch:
  - ifid_valid<=0 and ifid_instr<=16'h0000 (bubbles behind the HALT).
  - pc_out and fetch_count hold; halted stays 1.
  - The HALT word is delivered exactly once.
- Latency:
  - An instruction at address A appears on ifid_instr one edge after pc_out==A, provided no stall.
  - A redirect takes effect on pc_out one edge after branch_taken, and the first target instruction is valid in IF/ID one edge later.
- fetch_count saturates: at 16'hFFFF, further captures leave it at 16'hFFFF.
- Only HALT_WORD, rst or branch_taken change the state; stall never changes it.

Test Plan:
- Reset, then 3 free-running cycles on the demo program -> ifid (pc,instr) = (0000,FE21), (0002,FB22), (0004,2388); pc_out=0006; fetch_count=3.
- stall held 2 cycles with pc_out=0008 -> pc_out stays 0008, ifid stays (0006,149A); after release, ifid=(0008,F564) and fetch_count increments once.
- branch_taken with branch_target=002D while pc_out=0026 -> pc_out=002C next edge, ifid_valid=0; the next edge gives ifid=(002C,F111) with valid=1.
- Run to 003E (HALT) -> ifid=(003E,0000) valid=1 and halted=1 on that edge; the following cycles give ifid_valid=0 with pc_out stuck at 003E.
- Halt cancel: branch_taken with target 0030 on the cycle after HALT is captured -> halted=0, pc_out=0030; the next fetch is ifid=(0030,C890).
- branch_taken and stall asserted together -> branch wins, the PC redirects and IF/ID is flushed. Separately, force pc_out=FFFE via branch, then run -> pc_out=0000 the next edge. rst asserted in HALT -> all reset values the next edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fills the IF/ID buffer, and
// handles stalls, branch redirects/flushes and stopping on a HALT word.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] instr_in,
    output logic [15:0] pc_out,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam int unsigned W_DATA = 16;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              r_state;
    logic [W_DATA-1:0]   r_pc;
    logic [W_DATA-1:0]   r_ifid_instr;
    logic [W_DATA-1:0]   r_ifid_pc;
    logic                r_ifid_valid;
    logic                r_halted;
    logic [W_DATA-1:0]   r_fetch_count;

    logic                w_is_halt;
    logic [W_DATA-1:0]   w_count_inc;
    logic [W_DATA-1:0]   w_target;

    // Decode the fetched word, saturating count increment and aligned target.
    always_comb begin
        w_is_halt   = (instr_in == HALT_WORD);
        w_count_inc = (r_fetch_count == {W_DATA{1'b1}}) ? r_fetch_count
                                                        : r_fetch_count + W_DATA'(1);
        w_target    = branch_target & 16'hFFFE;
    end

    // Fetch FSM: priority is reset, then redirect, then stall, then state action.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_ifid_instr  <= '0;
            r_ifid_pc     <= '0;
            r_ifid_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else if (branch_taken) begin
            r_state      <= S_RUN;
            r_pc         <= w_target;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_RUN: begin
                    r_ifid_instr  <= instr_in;
                    r_ifid_pc     <= r_pc;
                    r_ifid_valid  <= 1'b1;
                    r_fetch_count <= w_count_inc;
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                S_HALT: begin
                    r_ifid_instr <= '0;
                    r_ifid_valid <= 1'b0;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_valid  = r_ifid_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a per-cycle scoreboard fed from a
// small reference model, plus directed constant checks for each scenario.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] instr_in;
    logic [15:0] pc_out;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Expected outputs: pc_out, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count
    typedef logic [65:0] exp_t;
    exp_t sb[$];

    logic [15:0] m_pc = 16'h0000;
    logic        m_halt = 1'b0;
    logic [15:0] m_cnt = 16'h0000;
    logic [15:0] m_ipc = 16'h0000;
    logic [15:0] m_iins = 16'h0000;
    logic        m_iv = 1'b0;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Demo program; unlisted addresses hold a non-HALT filler word.
    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: imem = 16'hFE21;
            16'h0002: imem = 16'hFB22;
            16'h0004: imem = 16'h2388;
            16'h0006: imem = 16'h149A;
            16'h0008: imem = 16'hF564;
            16'h002C: imem = 16'hF111;
            16'h0030: imem = 16'hC890;
            16'h003E: imem = 16'h0000;
            default:  imem = 16'h8000 | a;
        endcase
    endfunction

    always_comb instr_in = imem(pc_out);

    // One clock cycle: drive inputs, push the model's expectation, advance.
    task automatic drive_cycle(input logic r, input logic st, input logic br,
                               input logic [15:0] tgt);
        logic [15:0] w;
        rst = r; stall = st; branch_taken = br; branch_target = tgt;
        if (r) begin
            m_pc = 16'h0000; m_halt = 1'b0; m_cnt = 16'h0000;
            m_ipc = 16'h0000; m_iins = 16'h0000; m_iv = 1'b0;
        end else if (br) begin
            m_pc = tgt & 16'hFFFE; m_halt = 1'b0;
            m_ipc = 16'h0000; m_iins = 16'h0000; m_iv = 1'b0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (m_halt) begin
            m_iins = 16'h0000; m_iv = 1'b0;
        end else begin
            w = imem(m_pc);
            m_ipc = m_pc; m_iins = w; m_iv = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (w == 16'h0000) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
        sb.push_back({m_pc, m_ipc, m_iins, m_iv, m_halt, m_cnt});
        @(posedge clk);
        #2;
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    endtask

    // Scoreboard monitor: compares every edge's outputs with the queued expectation.
    initial begin
        exp_t e;
        exp_t o;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                o = {pc_out, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count};
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got pc=%h ifid=(%h,%h,v%b) halted=%b cnt=%h, expected pc=%h ifid=(%h,%h,v%b) halted=%b cnt=%h",
                             $time, o[65:50], o[49:34], o[33:18], o[17], o[16], o[15:0],
                             e[65:50], e[49:34], e[33:18], e[17], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic test_reset;
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count} !== 66'h0) begin
            errors++;
            $display("FAIL reset: got pc=%h instr=%h ipc=%h v=%b h=%b cnt=%h, expected all zero",
                     pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count);
        end
    endtask

    task automatic test_sequential;
        logic [15:0] epc [3];
        logic [15:0] ein [3];
        epc[0] = 16'h0000; epc[1] = 16'h0002; epc[2] = 16'h0004;
        ein[0] = 16'hFE21; ein[1] = 16'hFB22; ein[2] = 16'h2388;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (ifid_pc !== epc[i] || ifid_instr !== ein[i] || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch%0d: got (%h,%h,v%b) expected (%h,%h,v1)",
                         i, ifid_pc, ifid_instr, ifid_valid, epc[i], ein[i]);
            end
        end
        checks++;
        if (pc_out !== 16'h0006 || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL seq_pc_count: got pc=%h cnt=%0d expected pc=0006 cnt=3", pc_out, fetch_count);
        end
    endtask

    task automatic test_stall;
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
            checks++;
            if (pc_out !== 16'h0008 || ifid_pc !== 16'h0006 || ifid_instr !== 16'h149A || fetch_count !== 16'd4) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h ifid=(%h,%h) cnt=%0d expected pc=0008 ifid=(0006,149A) cnt=4",
                         i, pc_out, ifid_pc, ifid_instr, fetch_count);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (ifid_pc !== 16'h0008 || ifid_instr !== 16'hF564 || fetch_count !== 16'd5) begin
            errors++;
            $display("FAIL stall_release: got ifid=(%h,%h) cnt=%0d expected (0008,F564) cnt=5",
                     ifid_pc, ifid_instr, fetch_count);
        end
    endtask

    task automatic run_to(input logic [15:0] target);
        int n = 0;
        while (pc_out !== target && n < 100) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
            n++;
        end
        checks++;
        if (pc_out !== target) begin
            errors++;
            $display("FAIL run_to: got pc=%h expected %h within 100 cycles", pc_out, target);
        end
    endtask

    task automatic test_branch;
        run_to(16'h0026);
        drive_cycle(1'b0, 1'b0, 1'b1, 16'h002D);
        checks++;
        if (pc_out !== 16'h002C || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin
            errors++;
            $display("FAIL branch_redirect: got pc=%h v=%b instr=%h expected pc=002C v=0 instr=0000",
                     pc_out, ifid_valid, ifid_instr);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (ifid_pc !== 16'h002C || ifid_instr !== 16'hF111 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_first: got (%h,%h,v%b) expected (002C,F111,v1)", ifid_pc, ifid_instr, ifid_valid);
        end
    endtask

    task automatic test_halt;
        logic [15:0] cnt_at_halt;
        run_to(16'h003E);
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        cnt_at_halt = m_cnt;
        checks++;
        if (ifid_pc !== 16'h003E || ifid_instr !== 16'h0000 || ifid_valid !== 1'b1 || halted !== 1'b1 || pc_out !== 16'h003E) begin
            errors++;
            $display("FAIL halt_capture: got ifid=(%h,%h,v%b) h=%b pc=%h expected (003E,0000,v1) h=1 pc=003E",
                     ifid_pc, ifid_instr, ifid_valid, halted, pc_out);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (ifid_valid !== 1'b0 || pc_out !== 16'h003E || halted !== 1'b1 || fetch_count !== cnt_at_halt) begin
                errors++;
                $display("FAIL halt_bubble%0d: got v=%b pc=%h h=%b cnt=%0d expected v=0 pc=003E h=1 cnt=%0d",
                         i, ifid_valid, pc_out, halted, fetch_count, cnt_at_halt);
            end
        end
    endtask

    task automatic test_halt_cancel;
        drive_cycle(1'b0, 1'b0, 1'b1, 16'h0030);
        checks++;
        if (halted !== 1'b0 || pc_out !== 16'h0030 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_cancel: got h=%b pc=%h v=%b expected h=0 pc=0030 v=0", halted, pc_out, ifid_valid);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (ifid_pc !== 16'h0030 || ifid_instr !== 16'hC890 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_cancel_fetch: got (%h,%h,v%b) expected (0030,C890,v1)", ifid_pc, ifid_instr, ifid_valid);
        end
    endtask

    task automatic test_branch_stall;
        drive_cycle(1'b0, 1'b1, 1'b1, 16'h1001);
        checks++;
        if (pc_out !== 16'h1000 || ifid_valid !== 1'b0 || ifid_pc !== 16'h0000) begin
            errors++;
            $display("FAIL branch_over_stall: got pc=%h v=%b ipc=%h expected pc=1000 v=0 ipc=0000",
                     pc_out, ifid_valid, ifid_pc);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        checks++;
        if (pc_out !== 16'h1000 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL stalled_bubble: got pc=%h v=%b expected pc=1000 v=0", pc_out, ifid_valid);
        end
    endtask

    task automatic test_wrap;
        drive_cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);
        checks++;
        if (pc_out !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_target: got pc=%h expected FFFE", pc_out);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (pc_out !== 16'h0000 || ifid_pc !== 16'hFFFE || ifid_instr !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h ifid=(%h,%h) expected pc=0000 ifid=(FFFE,FFFE)", pc_out, ifid_pc, ifid_instr);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (ifid_pc !== 16'h0000 || ifid_instr !== 16'hFE21) begin
            errors++;
            $display("FAIL wrap_fetch: got ifid=(%h,%h) expected (0000,FE21)", ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_reset_in_halt;
        drive_cycle(1'b0, 1'b0, 1'b1, 16'h003E);
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        checks++;
        if (halted !== 1'b1 || ifid_valid !== 1'b1 || ifid_pc !== 16'h003E) begin
            errors++;
            $display("FAIL halt_stall_hold: got h=%b v=%b ipc=%h expected h=1 v=1 ipc=003E", halted, ifid_valid, ifid_pc);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count} !== 66'h0) begin
            errors++;
            $display("FAIL reset_in_halt: got pc=%h instr=%h ipc=%h v=%b h=%b cnt=%h, expected all zero",
                     pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_branch;
        test_halt;
        test_halt_cancel;
        test_branch_stall;
        test_wrap;
        test_reset_in_halt;
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
